// File: rtl/uart_word_tx_if.sv
// Word handshake between the DDR2 readout stage and the UART transmitter.
// The readout stage is the master; the transmitter is the slave.
interface uart_word_tx_if;
    logic [31:0] tx_data_in;
    logic        tx_data_ready;
    logic        tx_ready;

    modport master (
        output tx_data_in,
        output tx_data_ready,
        input  tx_ready
    );

    modport slave (
        input  tx_data_in,
        input  tx_data_ready,
        output tx_ready
    );
endinterface

// File: rtl/uart_word_tx.sv
// Word-to-serial 8N1 transmitter: one 32-bit word as four bytes, MSB byte first.
// tx_ready stays low for the whole word so the readout stage is paced by the link.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset,
    uart_word_tx_if.slave bus,
    output logic          tx,
    output logic          tx_word_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_n;
    logic [1:0]    byte_idx;
    logic [1:0]    byte_n;
    logic [31:0]   word_reg;
    logic [31:0]   word_n;
    logic          tx_n;
    logic          done_n;
    logic          bit_end;

    assign bit_end      = (cnt == LAST);
    assign bus.tx_ready = (state == IDLE);

    // Next state, counters and the registered line value for the next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        word_n  = word_reg;
        done_n  = 1'b0;
        tx_n    = 1'b1;

        unique case (state)
            IDLE: begin
                if (bus.tx_data_ready) begin
                    word_n  = bus.tx_data_in;
                    state_n = START;
                    cnt_n   = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (byte_idx == 2'd3) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        byte_n  = byte_idx + 2'd1;
                        state_n = START;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase

        // Byte k lives at word[8*(3-k) +: 8]; ~byte_n equals 3-byte_n.
        unique case (state_n)
            IDLE:  tx_n = 1'b1;
            START: tx_n = 1'b0;
            DATA:  tx_n = word_n[{~byte_n, bit_n}];
            STOP:  tx_n = 1'b1;
        endcase
    end

    // State, counters, shift word and the glitch-free tx flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            word_reg     <= '0;
            tx           <= 1'b1;
            tx_word_done <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_n;
            byte_idx     <= byte_n;
            word_reg     <= word_n;
            tx           <= tx_n;
            tx_word_done <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx at 4 and 868 clocks per bit.
// Expected bytes are queued at send time and popped as the line is decoded.
module tb_uart_word_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx_f;
    logic done_f;
    logic tx_s;
    logic done_s;

    uart_word_tx_if bus_f ();
    uart_word_tx_if bus_s ();

    uart_word_tx #(.CLKS_PER_BIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_f),
        .tx           (tx_f),
        .tx_word_done (done_f)
    );

    uart_word_tx #(.CLKS_PER_BIT(868)) dut_slow (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_s),
        .tx           (tx_s),
        .tx_word_done (done_s)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_hi = 0;
    int done_hi = 0;
    bit slow = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic tx_line();
        return slow ? tx_s : tx_f;
    endfunction

    function automatic logic rdy();
        return slow ? bus_s.tx_ready : bus_f.tx_ready;
    endfunction

    function automatic logic done_o();
        return slow ? done_s : done_f;
    endfunction

    function automatic int cpb();
        return slow ? 868 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] d, input logic s);
        if (slow) begin
            bus_s.tx_data_in    = d;
            bus_s.tx_data_ready = s;
        end else begin
            bus_f.tx_data_in    = d;
            bus_f.tx_data_ready = s;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] d2,
                        input int hold);
        push_word(d);
        set_in(d, 1'b1);
        @(negedge clk);
        for (int i = 1; i < hold; i++) begin
            set_in(d2, 1'b1);
            @(negedge clk);
        end
        set_in(d2, 1'b0);
    endtask

    task automatic wait_start(output bit ok, output int t);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_line() === 1'b0) begin
                ok = 1'b1;
                t = cyc;
                return;
            end
            @(negedge clk);
        end
        check("start_timeout", 1, 0);
    endtask

    task automatic rx_byte(input int t0, input int idx, output bit ok);
        logic [7:0] e;
        logic       eb;
        logic       prev;
        int         ts;
        int         good;
        int         last_edge;
        wait_start(ok, ts);
        if (!ok) return;
        check($sformatf("byte%0d_start", idx), ts - t0, idx * 10 * cpb());
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        prev = 1'b1;
        last_edge = ts;
        for (int b = 0; b < 10; b++) begin
            eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
            good = 0;
            for (int c = 0; c < cpb(); c++) begin
                if (tx_line() === eb) good++;
                if (tx_line() !== prev) begin
                    check("edge_gap", (cyc - last_edge) % cpb(), 0);
                    last_edge = cyc;
                    prev = tx_line();
                end
                rdy_hi += int'(rdy());
                done_hi += int'(done_o());
                @(negedge clk);
            end
            check($sformatf("byte%0d_bit%0d", idx, b), good, cpb());
        end
    endtask

    task automatic rx_word(output int t_start, output int t_done);
        int t0;
        bit ok;
        t_start = 0;
        t_done = 0;
        rdy_hi = 0;
        done_hi = 0;
        wait_start(ok, t0);
        if (!ok) return;
        t_start = t0;
        for (int i = 0; i < 4; i++) begin
            rx_byte(t0, i, ok);
            if (!ok) return;
        end
        check("ready_low", rdy_hi, 0);
        check("done_quiet", done_hi, 0);
        check("done_pulse", done_o(), 1);
        check("ready_back", rdy(), 1);
        check("word_len", cyc - t0, 40 * cpb());
        check("idle_line", tx_line(), 1);
        t_done = cyc;
        @(negedge clk);
        check("done_one_cycle", done_o(), 0);
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_tx"}, tx_f, 1);
        check({tag, "_ready"}, bus_f.tx_ready, 1);
        check({tag, "_done"}, done_f, 0);
    endtask

    initial begin
        int  ts;
        int  td;
        int  ts2;
        int  td2;
        int  zeros;
        bit  ok;
        bus_f.tx_data_in = '0;
        bus_f.tx_data_ready = 1'b0;
        bus_s.tx_data_in = '0;
        bus_s.tx_data_ready = 1'b0;
        repeat (2) @(negedge clk);
        idle_checks("rst");
        check("rst_slow_tx", tx_s, 1);
        reset = 1'b1;
        @(negedge clk);

        // Reset asserted mid-word while the line is low.
        set_in(32'h0, 1'b1);
        @(negedge clk);
        set_in(32'h0, 1'b0);
        repeat (6) @(negedge clk);
        check("s1_mid_tx", tx_f, 0);
        reset = 1'b0;
        #1;
        idle_checks("s1_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_checks("s1_hold");
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_checks("s1_after");
        end
        exp_q.delete();

        // Single-cycle strobe.
        fork
            send(32'hA55A0FF0, 32'hA55A0FF0, 1);
            rx_word(ts, td);
        join

        // Two-cycle strobe; the second value must be ignored.
        fork
            send(32'hC3E17B2D, 32'h11112222, 2);
            rx_word(ts, td);
        join
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_f !== 1'b1 || bus_f.tx_ready !== 1'b1) zeros++;
            @(negedge clk);
        end
        check("s3_no_extra", zeros, 0);

        // Strobe held high across two words.
        fork
            begin
                push_word(32'h00000001);
                push_word(32'hFFFFFFFF);
                set_in(32'h00000001, 1'b1);
                @(negedge clk);
                set_in(32'hFFFFFFFF, 1'b1);
                for (int i = 0; i < 400 && !rdy(); i++) @(negedge clk);
                @(negedge clk);
                set_in(32'hFFFFFFFF, 1'b0);
            end
            begin
                rx_word(ts, td);
                check("s4_back2back", tx_f, 0);
                rx_word(ts2, td2);
                check("s4_gap", ts2 - td, 1);
            end
        join
        repeat (4) @(negedge clk);
        check("s4_drained", exp_q.size(), 0);

        // Reset during byte 2, data bit 3.
        fork
            send(32'hFFFF00FF, 32'hFFFF00FF, 1);
            begin
                wait_start(ok, ts);
                repeat (97) @(negedge clk);
                check("s5_pre", tx_f, 0);
                reset = 1'b0;
                #1;
                idle_checks("s5_async");
            end
        join
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        idle_checks("s5_after");
        fork
            send(32'h12345678, 32'h12345678, 1);
            rx_word(ts, td);
        join

        // Full-rate divider.
        slow = 1'b1;
        fork
            send(32'hA55A0FF0, 32'hA55A0FF0, 1);
            rx_word(ts, td);
        join
        check("s6_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
